// File: rtl/matrix_weight_sequencer.sv
// matrix_weight_sequencer
//   Programs or verifies the off-diagonal coupling weights of the Ising coupling
//   matrix through its shared port. A sweep visits every (s, d) cell with s != d,
//   s outer and d inner. For each cell one 32-bit weight is taken from the input
//   stream. That weight is then either written into the cell or compared with the
//   cell's read data.
//
// Ports
//   clk, axi_rstn            clock, asynchronous active-low reset
//   start, mode, abort       command pulse, 0=write/1=verify (sampled with start), abort
//   in_valid/in_data/in_ready weight stream
//   wready, wr_match          matrix write strobe and cell select
//   s_addr, d_addr, s_gt_d    registered cell address and its ordering flag
//   wdata, rdata              weight to the matrix, combinational read data back
//   busy, done, aborted       status: sweep active, completion pulse, sticky abort
//   mismatch_cnt              saturating verify-mismatch count for the last sweep
module matrix_weight_sequencer #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          axi_rstn,
  input  logic          start,
  input  logic          mode,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  output logic          in_ready,
  output logic          wready,
  output logic          wr_match,
  output logic [AW-1:0] s_addr,
  output logic [AW-1:0] d_addr,
  output logic          s_gt_d,
  output logic [31:0]   wdata,
  input  logic [31:0]   rdata,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [15:0]   mismatch_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] S_LAST = AW'(N - 1);
  localparam logic [AW-1:0] D_LAST = AW'(N - 2);

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] s_q, s_d;
  logic [AW-1:0] d_q, d_d;
  logic          s_gt_d_q, s_gt_d_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   mism_q, mism_d;
  logic          aborted_q, aborted_d;

  logic [AW:0]   d_plus1_s, d_plus2_s, d_step_s;
  logic [AW-1:0] s_adv_s, d_adv_s;
  logic          last_cell_s;

  // Next cell in sweep order: d steps over the diagonal, wraps into the next s row.
  always_comb begin
    d_plus1_s = {1'b0, d_q} + {{AW{1'b0}}, 1'b1};
    d_plus2_s = d_plus1_s + {{AW{1'b0}}, 1'b1};
    if (d_plus1_s == {1'b0, s_q}) begin
      d_step_s = d_plus2_s;
    end else begin
      d_step_s = d_plus1_s;
    end
    if (d_step_s >= (AW+1)'(N)) begin
      s_adv_s = s_q + AW'(1'b1);
      // Row 0 must start at column 1 to skip the diagonal.
      if (s_adv_s == {AW{1'b0}}) begin
        d_adv_s = AW'(1'b1);
      end else begin
        d_adv_s = {AW{1'b0}};
      end
    end else begin
      s_adv_s = s_q;
      d_adv_s = d_step_s[AW-1:0];
    end
    last_cell_s = (s_q == S_LAST) && (d_q == D_LAST);
  end

  // Sweep state machine: next state and next values of every register.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    s_d       = s_q;
    d_d       = d_q;
    wdata_d   = wdata_q;
    mism_d    = mism_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        // start beats abort here; abort is meaningless while idle.
        if (start) begin
          mode_d    = mode;
          mism_d    = 16'h0000;
          aborted_d = 1'b0;
          s_d       = {AW{1'b0}};
          d_d       = AW'(1'b1);
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (in_valid) begin
          wdata_d = in_data;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        // A write strobe already on the port this cycle completes even on abort.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (mode_q) begin
          state_d = ST_CHECK;
        end else begin
          s_d     = s_adv_s;
          d_d     = d_adv_s;
          state_d = last_cell_s ? ST_DONE : ST_FETCH;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          if ((rdata != wdata_q) && (mism_q != 16'hFFFF)) begin
            mism_d = mism_q + 16'd1;
          end else begin
            mism_d = mism_q;
          end
          s_d     = s_adv_s;
          d_d     = d_adv_s;
          state_d = last_cell_s ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else begin
          aborted_d = aborted_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    s_gt_d_d = (s_d > d_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      s_q       <= {AW{1'b0}};
      d_q       <= {AW{1'b0}};
      s_gt_d_q  <= 1'b0;
      wdata_q   <= 32'h0000_0000;
      mism_q    <= 16'h0000;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      s_q       <= s_d;
      d_q       <= d_d;
      s_gt_d_q  <= s_gt_d_d;
      wdata_q   <= wdata_d;
      mism_q    <= mism_d;
      aborted_q <= aborted_d;
    end
  end

  // Port controls are pure decodes of the state register.
  assign in_ready     = (state_q == ST_FETCH);
  assign wr_match     = (state_q == ST_ISSUE) || (state_q == ST_CHECK);
  assign wready       = (state_q == ST_ISSUE) && !mode_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign s_addr       = s_q;
  assign d_addr       = d_q;
  assign s_gt_d       = s_gt_d_q;
  assign wdata        = wdata_q;
  assign aborted      = aborted_q;
  assign mismatch_cnt = mism_q;

endmodule

// File: tb/tb_matrix_weight_sequencer.sv
// Directed bench for matrix_weight_sequencer at N=4 (12 cells per sweep).
module tb_matrix_weight_sequencer;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk;
  logic          axi_rstn;
  logic          start;
  logic          mode;
  logic          abort;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          wready;
  logic          wr_match;
  logic [AW-1:0] s_addr;
  logic [AW-1:0] d_addr;
  logic          s_gt_d;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [15:0]   mismatch_cnt;

  // Model of the coupling matrix: written on wready, read combinationally.
  logic [31:0] mem [0:N-1][0:N-1];
  assign rdata = mem[s_addr][d_addr];

  matrix_weight_sequencer #(.N(N)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .start(start), .mode(mode), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wready(wready), .wr_match(wr_match), .s_addr(s_addr), .d_addr(d_addr),
    .s_gt_d(s_gt_d), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .aborted(aborted), .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cyc0 = 0;
  int idx = 0;
  int base = 0;
  int nw = 0;
  int ndone = 0;
  int nd0 = 0;
  int nw0 = 0;
  logic [1:0]  log_s  [0:15];
  logic [1:0]  log_d  [0:15];
  logic        log_gt [0:15];
  logic [31:0] log_w  [0:15];

  int exp_s [0:11] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int exp_d [0:11] = '{1, 2, 3, 0, 2, 3, 0, 1, 3, 0, 1, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: record strobes and handshakes before the edge, advance the stream after.
  task automatic tick();
    logic hs;
    hs = in_ready && in_valid;
    if (wready) begin
      if (nw < 16) begin
        log_s[nw] = s_addr; log_d[nw] = d_addr; log_gt[nw] = s_gt_d; log_w[nw] = wdata;
      end
      mem[s_addr][d_addr] = wdata;
      nw++;
    end
    if (done) ndone++;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      idx++;
      in_data = 32'(base + idx + 1);
    end
  endtask

  task automatic do_start(input logic m);
    idx = 0; nw = 0;
    in_data = 32'(base + 1);
    in_valid = 1'b1;
    mode = m; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic run_to_done(input string tag);
    while (!done && (cyc - cyc0) < 300) tick();
    chk({tag, "_reached_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_strobes"}, 32'(nw), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s_s[%0d]", tag, i), 32'(log_s[i]), 32'(exp_s[i]));
      chk($sformatf("%s_d[%0d]", tag, i), 32'(log_d[i]), 32'(exp_d[i]));
      chk($sformatf("%s_gt[%0d]", tag, i), 32'(log_gt[i]), 32'(exp_s[i] > exp_d[i]));
      chk($sformatf("%s_w[%0d]", tag, i), log_w[i], 32'(base + i + 1));
    end
  endtask

  initial begin
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        mem[a][b] = 32'hDEAD_0000;
    axi_rstn = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = 32'h0;

    // Reset values
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_wr_match", 32'(wr_match), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_s", 32'(s_addr), 32'd0);
    chk("rst_d", 32'(d_addr), 32'd0);
    chk("rst_gt", 32'(s_gt_d), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_mism", 32'(mismatch_cnt), 32'd0);
    #10 axi_rstn = 1'b1;
    tick();

    // Write sweep, data 1..12 back to back; done is the 26th cycle counting the start cycle
    base = 0;
    do_start(1'b0);
    chk("wr_first_s", 32'(s_addr), 32'd0);
    chk("wr_first_d", 32'(d_addr), 32'd1);
    run_to_done("wr");
    chk("wr_edges", 32'(cyc - cyc0 + 1), 32'd25);
    check_log("wr");
    chk("wr_mism", 32'(mismatch_cnt), 32'd0);
    tick();
    chk("wr_idle_busy", 32'(busy), 32'd0);
    chk("wr_idle_done", 32'(done), 32'd0);

    // Verify against the model with cell (2,1) corrupted: 3 cycles per cell
    mem[2][1] = mem[2][1] ^ 32'h0000_0100;
    base = 0;
    do_start(1'b1);
    run_to_done("vf");
    chk("vf_edges", 32'(cyc - cyc0 + 1), 32'd37);
    chk("vf_mism", 32'(mismatch_cnt), 32'd1);
    chk("vf_no_wready", 32'(nw), 32'd0);
    tick();

    // Stall: in_valid low across the fetch of cell 3
    base = 100;
    do_start(1'b0);
    while (idx < 2 && (cyc - cyc0) < 50) tick();
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_in_ready[%0d]", k), 32'(in_ready), 32'd1);
      chk($sformatf("stall_wr_match[%0d]", k), 32'(wr_match), 32'd0);
      tick();
    end
    in_valid = 1'b1;
    run_to_done("st");
    chk("st_edges", 32'(cyc - cyc0 + 1), 32'd30);
    check_log("st");
    tick();

    // Abort in ISSUE of cell 5 (1,2); its write strobe still completes
    base = 200;
    do_start(1'b0);
    while (idx < 5 && (cyc - cyc0) < 50) tick();
    chk("ab_wready", 32'(wready), 32'd1);
    chk("ab_cell_s", 32'(s_addr), 32'd1);
    chk("ab_cell_d", 32'(d_addr), 32'd2);
    nd0 = ndone;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_aborted", 32'(aborted), 32'd1);
    chk("ab_wr_match", 32'(wr_match), 32'd0);
    chk("ab_strobes", 32'(nw), 32'd5);
    tick(); tick(); tick();
    chk("ab_no_done", 32'(ndone - nd0), 32'd0);
    chk("ab_sticky", 32'(aborted), 32'd1);

    // Restart with abort asserted alongside start: start wins, aborted clears
    base = 300;
    idx = 0; nw = 0;
    in_data = 32'(base + 1); in_valid = 1'b1;
    mode = 1'b0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    cyc0 = cyc;
    chk("rs_aborted", 32'(aborted), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_s", 32'(s_addr), 32'd0);
    chk("rs_d", 32'(d_addr), 32'd1);
    // A verify-mode start mid-sweep must be ignored
    tick(); tick(); tick(); tick();
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    run_to_done("bz");
    chk("bz_edges", 32'(cyc - cyc0 + 1), 32'd25);
    check_log("bz");
    tick();

    // Asynchronous reset during ISSUE of cell (0,1)
    base = 400;
    do_start(1'b0);
    while (idx < 1 && (cyc - cyc0) < 50) tick();
    chk("ar_pre_wready", 32'(wready), 32'd1);
    chk("ar_pre_match", 32'(wr_match), 32'd1);
    #3 axi_rstn = 1'b0;
    #1;
    chk("ar_wready", 32'(wready), 32'd0);
    chk("ar_wr_match", 32'(wr_match), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_s", 32'(s_addr), 32'd0);
    chk("ar_d", 32'(d_addr), 32'd0);
    chk("ar_gt", 32'(s_gt_d), 32'd0);
    chk("ar_wdata", wdata, 32'd0);
    chk("ar_aborted", 32'(aborted), 32'd0);
    chk("ar_mism", 32'(mismatch_cnt), 32'd0);
    #2 axi_rstn = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("ar_stays_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
